// File: rtl/vga_text_console.sv
// vga_text_console: byte stream to vga text write port.
// Cursor over a COLS x ROWS grid, control codes, clear sweep.
module vga_text_console #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 24,
  parameter int          POS_W      = 11,
  parameter logic [7:0]  BLANK_CHAR = 8'h00
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [7:0]       write_char,
  output logic [POS_W-1:0] write_char_pos,
  output logic             write_char_strobe,
  output logic [POS_W-1:0] cursor_pos,
  output logic             busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  localparam logic [POS_W-1:0] COLS_P = POS_W'(COLS);
  localparam logic [POS_W-1:0] LAST_P = POS_W'(COLS * ROWS - 1);
  localparam logic [POS_W:0]   TOTAL_X = (POS_W + 1)'(COLS * ROWS);

  logic [0:0]       state;
  logic [POS_W-1:0] clr_cnt;
  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row_start;
  logic [POS_W:0]   nl_pos;
  logic             accept;

  // Newline target is computed one bit wider so the wrap compare
  // stays correct even when the grid fills the whole POS_W range.
  always_comb begin
    row_start = cursor_pos - col;
    nl_pos    = {1'b0, row_start} + {1'b0, COLS_P};
    accept    = data_valid && data_ready;
  end

  // Clear sweep, byte decode and cursor tracking.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state             <= CLEAR;
      clr_cnt           <= '0;
      cursor_pos        <= '0;
      col               <= '0;
      write_char        <= BLANK_CHAR;
      write_char_pos    <= '0;
      write_char_strobe <= 1'b0;
      busy              <= 1'b1;
      data_ready        <= 1'b0;
    end else begin
      write_char_strobe <= 1'b0;
      if (state == CLEAR) begin
        write_char_strobe <= 1'b1;
        write_char        <= BLANK_CHAR;
        write_char_pos    <= clr_cnt;
        clr_cnt           <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_P) begin
          state      <= IDLE;
          busy       <= 1'b0;
          data_ready <= 1'b1;
          cursor_pos <= '0;
          col        <= '0;
          clr_cnt    <= '0;
        end
      end else if (accept) begin
        unique case (1'b1)
          (data_in == 8'h0A): begin
            cursor_pos <= (nl_pos >= TOTAL_X) ? '0
                        : nl_pos[POS_W-1:0];
            col        <= '0;
          end
          (data_in == 8'h0D): begin
            cursor_pos <= row_start;
            col        <= '0;
          end
          (data_in == 8'h08): begin
            if (cursor_pos != '0) begin
              write_char_strobe <= 1'b1;
              write_char        <= BLANK_CHAR;
              write_char_pos    <= cursor_pos - 1'b1;
              cursor_pos        <= cursor_pos - 1'b1;
              col <= (col != '0) ? col - 1'b1
                   : COLS_P - 1'b1;
            end
          end
          (data_in == 8'h0C): begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            busy       <= 1'b1;
            data_ready <= 1'b0;
            cursor_pos <= '0;
            col        <= '0;
          end
          default: begin
            write_char_strobe <= 1'b1;
            write_char        <= data_in;
            write_char_pos    <= cursor_pos;
            cursor_pos <= (cursor_pos == LAST_P) ? '0
                        : cursor_pos + 1'b1;
            col <= (col == COLS_P - 1'b1) ? '0
                 : col + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: directed vectors for vga_text_console.
// Table of bytes with expected outputs plus clear/reset sequences.
module tb_vga_text_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int POS_W = 11;
  localparam int TOTAL = COLS * ROWS;

  logic             CLK;
  logic             RST_N;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [7:0]       write_char;
  logic [POS_W-1:0] write_char_pos;
  logic             write_char_strobe;
  logic [POS_W-1:0] cursor_pos;
  logic             busy;

  vga_text_console #(
    .COLS(COLS), .ROWS(ROWS), .POS_W(POS_W), .BLANK_CHAR(8'h00)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .write_char(write_char),
    .write_char_pos(write_char_pos),
    .write_char_strobe(write_char_strobe),
    .cursor_pos(cursor_pos),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       stb;
    logic [7:0] ch;
    int         pos;
    int         cur;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_ch;
  int         last_pos;

  function automatic void add(input logic [7:0] d, input logic stb,
                              input logic [7:0] ch, input int pos,
                              input int cur);
    vec_t v;
    if (stb) begin
      last_ch  = ch;
      last_pos = pos;
    end
    v.d   = d;
    v.stb = stb;
    v.ch  = last_ch;
    v.pos = last_pos;
    v.cur = cur;
    v.rdy = (d != 8'h0C);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sweep(input string nm);
    int bad_stb = 0;
    int bad_bsy = 0;
    for (int i = 0; i < TOTAL; i++) begin
      @(posedge CLK);
      #1;
      if (!(write_char_strobe === 1'b1 && write_char === 8'h00 &&
            int'(write_char_pos) == i))
        bad_stb++;
      if (i < TOTAL - 1) begin
        if (!(busy === 1'b1 && data_ready === 1'b0)) bad_bsy++;
      end else begin
        chk({nm, "_done_busy"}, int'(busy), 0);
        chk({nm, "_done_ready"}, int'(data_ready), 1);
        data_valid = 1'b0;
      end
    end
    chk({nm, "_strobes_bad"}, bad_stb, 0);
    chk({nm, "_busy_bad"}, bad_bsy, 0);
    chk({nm, "_cursor"}, int'(cursor_pos), 0);
    @(posedge CLK);
    #1;
    chk({nm, "_strobe_end"}, int'(write_char_strobe), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;

    last_ch  = 8'h00;
    last_pos = TOTAL - 1;
    add(8'h01, 1, 8'h01, 0, 1);
    add(8'h0D, 0, 8'h00, 0, 0);
    for (int i = 0; i < 80; i++) add(8'h03, 1, 8'h03, i, i + 1);
    add(8'h08, 1, 8'h00, 79, 79);
    add(8'h05, 1, 8'h05, 79, 80);
    add(8'h0D, 0, 8'h00, 0, 80);
    add(8'h0A, 0, 8'h00, 0, 160);
    for (int i = 0; i < 5; i++) add(8'h06, 1, 8'h06, 160 + i, 161 + i);
    add(8'h0D, 0, 8'h00, 0, 160);
    for (int i = 0; i < 21; i++) add(8'h0A, 0, 8'h00, 0, 240 + 80 * i);
    for (int i = 0; i < 5; i++) add(8'h07, 1, 8'h07, 1840 + i, 1841 + i);
    add(8'h0A, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      add(8'h41 + 8'(i), 1, 8'h41 + 8'(i), i, i + 1);
    add(8'h08, 1, 8'h00, 9, 9);
    add(8'h0D, 0, 8'h00, 0, 0);
    add(8'h08, 0, 8'h00, 0, 0);
    for (int i = 0; i < 23; i++) add(8'h0A, 0, 8'h00, 0, 80 * (i + 1));
    for (int i = 0; i < 79; i++) add(8'h42, 1, 8'h42, 1840 + i, 1841 + i);
    add(8'h04, 1, 8'h04, 1919, 0);
    add(8'h0C, 0, 8'h00, 0, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_strobe", int'(write_char_strobe), 0);
    chk("rst_char", int'(write_char), 0);
    chk("rst_pos", int'(write_char_pos), 0);
    chk("rst_cursor", int'(cursor_pos), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(data_ready), 0);

    @(negedge CLK);
    RST_N = 1'b1;
    sweep("clr0");

    foreach (vecs[k]) begin
      @(negedge CLK);
      data_in    = vecs[k].d;
      data_valid = 1'b1;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_strobe", k), int'(write_char_strobe),
          int'(vecs[k].stb));
      chk($sformatf("v%0d_char", k), int'(write_char),
          int'(vecs[k].ch));
      chk($sformatf("v%0d_pos", k), int'(write_char_pos), vecs[k].pos);
      chk($sformatf("v%0d_cursor", k), int'(cursor_pos), vecs[k].cur);
      chk($sformatf("v%0d_ready", k), int'(data_ready),
          int'(vecs[k].rdy));
    end

    data_in = 8'h41;
    sweep("ff");

    @(negedge CLK);
    data_in    = 8'h0C;
    data_valid = 1'b1;
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
    chk("ff2_ready", int'(data_ready), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 700; i++) begin
        @(posedge CLK);
        #1;
        if (!(write_char_strobe === 1'b1 && int'(write_char_pos) == i))
          bad++;
      end
      chk("part_sweep_bad", bad, 0);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid_rst_strobe", int'(write_char_strobe), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_ready", int'(data_ready), 0);
    chk("mid_rst_pos", int'(write_char_pos), 0);
    chk("mid_rst_cursor", int'(cursor_pos), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    sweep("clr1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
